// File: rtl/jh_pkg.sv
// rtl/jh_pkg.sv - shared screen geometry, colour constants and fill-engine state encoding
package jh_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] BLACK  = 3'b000;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b110;
   localparam logic [2:0] CYAN   = 3'b011;
   localparam logic [2:0] WHITE  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rect_fill_writer.sv
// rtl/rect_fill_writer.sv - row-major rectangle fill engine driving the vga_adapter pixel port
module rect_fill_writer
   import jh_pkg::*;
#(
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int C_W = 3
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [X_W-1:0] cmd_x,
   input  logic [Y_W-1:0] cmd_y,
   input  logic [X_W-1:0] cmd_w,
   input  logic [Y_W-1:0] cmd_h,
   input  logic [C_W-1:0] cmd_colour,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [C_W-1:0] colour,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   // Cursor is one bit wider than the coordinate so x0+w-1 / y0+h-1 never wrap.
   localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
   localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
   localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

   state_t         state, state_nxt;
   logic [X_W:0]   cx, x0, x_last;
   logic [Y_W:0]   cy, y_last;
   logic [C_W-1:0] fill;
   logic           accept, zero_area, row_end, last_pixel;

   assign accept     = (state == ST_IDLE) && cmd_valid;
   assign zero_area  = (cmd_w == '0) || (cmd_h == '0);
   assign row_end    = (cx == x_last);
   assign last_pixel = row_end && (cy == y_last);

   // State register; reset abandons any rectangle in progress.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state: accept in IDLE, scan until the bottom-right pixel, one DONE cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = zero_area ? ST_DONE : ST_DRAW;
         ST_DRAW: if (last_pixel) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command latch and row-major cursor stepping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cx     <= '0;
         cy     <= '0;
         x0     <= '0;
         x_last <= '0;
         y_last <= '0;
         fill   <= '0;
      end else if (accept) begin
         cx     <= {1'b0, cmd_x};
         cy     <= {1'b0, cmd_y};
         x0     <= {1'b0, cmd_x};
         x_last <= {1'b0, cmd_x} + {1'b0, cmd_w} - X_ONE;
         y_last <= {1'b0, cmd_y} + {1'b0, cmd_h} - Y_ONE;
         fill   <= cmd_colour;
      end else if (state == ST_DRAW) begin
         if (row_end) begin
            cx <= x0;
            cy <= cy + Y_ONE;
         end else begin
            cx <= cx + X_ONE;
         end
      end
   end

   // Outputs depend only on registered state; off-screen pixels are stepped but not plotted.
   always_comb begin
      plot      = (state == ST_DRAW) && (cx < X_LIM) && (cy < Y_LIM);
      x         = cx[X_W-1:0];
      y         = cy[Y_W-1:0];
      colour    = fill;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      cmd_ready = (state == ST_IDLE);
   end

endmodule

// File: tb/tb_rect_fill_writer.sv
// tb/tb_rect_fill_writer.sv - randomized and directed self-checking bench for rect_fill_writer
module tb_rect_fill_writer;

   logic       clk;
   logic       resetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_x;
   logic [6:0] cmd_y;
   logic [7:0] cmd_w;
   logic [6:0] cmd_h;
   logic [2:0] cmd_colour;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   rect_fill_writer #(.X_W(8), .Y_W(7), .C_W(3)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_colour(cmd_colour),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 idle, 1 pixel, 2 done
   typedef struct {
      int kind;
      int px;
      int py;
      int c;
   } rec_t;

   rec_t q[$];
   rec_t cur;
   int   cyc;
   int   acc_cnt;
   int   acc_cyc;
   int   checks;
   int   errors;
   int   plot_cnt;
   int   busy_cnt;
   int   last_x;
   int   last_y;
   int   done_cyc;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: on acceptance, the whole per-cycle trace of the command is queued.
   initial begin
      cur = '{0, 0, 0, 0};
      cyc = 0;
      acc_cnt = 0;
      acc_cyc = 0;
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            q.delete();
            cur = '{0, 0, 0, 0};
         end else begin
            cyc++;
            if (cur.kind == 0 && cmd_valid) begin
               acc_cnt++;
               acc_cyc = cyc;
               for (int r = 0; r < int'(cmd_h); r++)
                  for (int c = 0; c < int'(cmd_w); c++)
                     q.push_back('{1, int'(cmd_x) + c, int'(cmd_y) + r, int'(cmd_colour)});
               q.push_back('{2, 0, 0, 0});
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{0, 0, 0, 0};
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      plot_cnt = 0;
      busy_cnt = 0;
      last_x = -1;
      last_y = -1;
      done_cyc = -1;
      forever begin
         @(negedge clk);
         begin
            bit exp_plot;
            exp_plot = (cur.kind == 1) && (cur.px < 160) && (cur.py < 120);
            chk("cmd_ready", int'(cmd_ready), int'(cur.kind == 0));
            chk("busy", int'(busy), int'(cur.kind != 0));
            chk("done", int'(done), int'(cur.kind == 2));
            chk("plot", int'(plot), int'(exp_plot));
            if (exp_plot) begin
               chk("x", int'(x), cur.px);
               chk("y", int'(y), cur.py);
               chk("colour", int'(colour), cur.c);
            end
            if (plot) begin
               plot_cnt++;
               last_x = int'(x);
               last_y = int'(y);
            end
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
         end
      end
   end

   task automatic send(input int sx, input int sy, input int sw, input int sh, input int sc);
      int start;
      int n;
      start = acc_cnt;
      n = 0;
      cmd_x = 8'(sx);
      cmd_y = 7'(sy);
      cmd_w = 8'(sw);
      cmd_h = 7'(sh);
      cmd_colour = 3'(sc);
      cmd_valid = 1'b1;
      while (acc_cnt == start && n < 30000) begin
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      if (acc_cnt == start) chk("accept_timeout", acc_cnt - start, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (cur.kind != 0 && n < 30000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (cur.kind != 0) chk("idle_timeout", cur.kind, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired time=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ex[6];
      int ey[6];
      int a1;
      ex = '{10, 11, 12, 10, 11, 12};
      ey = '{20, 20, 20, 21, 21, 21};
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      cmd_valid = 1'b0;
      cmd_x = '0;
      cmd_y = '0;
      cmd_w = '0;
      cmd_h = '0;
      cmd_colour = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_plot", int'(plot), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 3x2 fill with literal expectations
      send(10, 20, 3, 2, 6);
      a1 = acc_cyc;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("f32_plot", int'(plot), 1);
         chk("f32_x", int'(x), ex[k]);
         chk("f32_y", int'(y), ey[k]);
         chk("f32_colour", int'(colour), 6);
         chk("f32_model_x", cur.px, ex[k]);
         chk("f32_model_y", cur.py, ey[k]);
      end
      @(negedge clk);
      chk("f32_done", int'(done), 1);
      chk("f32_done_latency", done_cyc - a1, 6);
      @(negedge clk);
      chk("f32_ready_after", int'(cmd_ready), 1);
      @(posedge clk);
      #1;

      // clipping at the bottom-right corner
      plot_cnt = 0;
      busy_cnt = 0;
      send(158, 118, 4, 3, 2);
      wait_idle();
      chk("clip_plots", plot_cnt, 4);
      chk("clip_busy_cycles", busy_cnt, 13);
      chk("clip_last_x", last_x, 159);
      chk("clip_last_y", last_y, 119);

      // zero area
      plot_cnt = 0;
      send(5, 5, 0, 7, 7);
      a1 = acc_cyc;
      wait_idle();
      chk("zero_plots", plot_cnt, 0);
      chk("zero_done_latency", done_cyc - a1, 0);

      // backpressure: second command held until the IDLE cycle after done
      send(20, 30, 2, 2, 3);
      a1 = acc_cyc;
      send(0, 0, 1, 1, 3);
      plot_cnt = 0;
      chk("bp_accept_gap", acc_cyc - a1, 6);
      wait_idle();
      chk("bp_plots", plot_cnt, 1);
      chk("bp_last_x", last_x, 0);
      chk("bp_last_y", last_y, 0);

      // reset in the 4th DRAW cycle
      send(10, 20, 3, 2, 6);
      repeat (3) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_plot", int'(plot), 0);
      chk("mid_rst_ready", int'(cmd_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_x", int'(x), 0);
      chk("mid_rst_colour", int'(colour), 0);
      plot_cnt = 0;
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_rst_no_writes", plot_cnt, 0);

      // randomized commands with random gaps
      for (int i = 0; i < 40; i++) begin
         int rx, ry, rw, rh, rc;
         rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 255));
         ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
         rw = int'($urandom_range(0, 10));
         rh = int'($urandom_range(0, 5));
         rc = int'($urandom_range(0, 7));
         send(rx, ry, rw, rh, rc);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_idle();

      // full screen
      plot_cnt = 0;
      send(0, 0, 160, 120, 0);
      a1 = acc_cyc;
      wait_idle();
      chk("full_plots", plot_cnt, 19200);
      chk("full_last_x", last_x, 159);
      chk("full_last_y", last_y, 119);
      chk("full_done_latency", done_cyc - a1, 19200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
